// File: rtl/demux1to8_collector.sv
// Serial-to-parallel frame collector: strobed (addy, din) writes fill an
// N-bit word; a registered done pulse marks each complete frame.
module demux1to8_collector #(
   parameter int ADDR_W = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   valid,
   input  logic [ADDR_W-1:0]      addy,
   input  logic                   din,
   output logic [2**ADDR_W-1:0]   dout,
   output logic [2**ADDR_W-1:0]   filled,
   output logic                   done,
   output logic                   err
);

   localparam int N = 2**ADDR_W;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DONE
   } state_t;

   state_t         state;
   state_t         state_n;
   logic [N-1:0]   dout_n;
   logic [N-1:0]   filled_n;
   logic [N-1:0]   slot;
   logic [N-1:0]   merged;
   logic           done_n;
   logic           err_n;
   logic           acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         dout   <= '0;
         filled <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_n;
         dout   <= dout_n;
         filled <= filled_n;
         done   <= done_n;
         err    <= err_n;
      end
   end

   always_comb begin
      state_n  = state;
      dout_n   = dout;
      filled_n = filled;
      done_n   = 1'b0;
      err_n    = 1'b0;
      slot     = '0;
      slot[addy] = 1'b1;
      merged   = filled | slot;
      acc      = en && valid;

      if (!en) begin
         state_n  = IDLE;
         filled_n = '0;
      end else if (acc) begin
         dout_n[addy] = din;
         unique case (state)
            IDLE, DONE: begin
               // a write in DONE opens a fresh frame
               filled_n = slot;
               if (&slot) begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end else begin
                  state_n = COLLECT;
               end
            end
            COLLECT: begin
               if (filled[addy]) begin
                  err_n = 1'b1;
               end else begin
                  filled_n = merged;
                  if (&merged) begin
                     state_n = DONE;
                     done_n  = 1'b1;
                  end
               end
            end
            default: begin
               state_n  = IDLE;
               filled_n = '0;
            end
         endcase
      end else if (state == DONE) begin
         state_n  = IDLE;
         filled_n = '0;
      end
   end

endmodule

// File: tb/tb_demux1to8_collector.sv
// Randomised and directed bench for demux1to8_collector against a
// frame-level reference model.
module tb_demux1to8_collector;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       valid;
   logic [2:0] addy;
   logic       din;
   logic [7:0] dout;
   logic [7:0] filled;
   logic       done;
   logic       err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] m_dout;
   logic [7:0] m_filled;
   logic       m_done;
   logic       m_err;
   logic       fresh;

   demux1to8_collector dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .valid  (valid),
      .addy   (addy),
      .din    (din),
      .dout   (dout),
      .filled (filled),
      .done   (done),
      .err    (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Frame-level reference: a frame is complete when all eight slots
   // have been written; the cycle after completion begins a new frame.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_dout   = '0;
         m_filled = '0;
         m_done   = 1'b0;
         m_err    = 1'b0;
      end else if (!en) begin
         m_filled = '0;
         m_done   = 1'b0;
         m_err    = 1'b0;
      end else begin
         fresh  = m_done;
         m_done = 1'b0;
         m_err  = 1'b0;
         if (fresh) m_filled = '0;
         if (valid) begin
            if (m_filled[addy]) m_err = 1'b1;
            m_filled[addy] = 1'b1;
            m_dout[addy]   = din;
            if ($countones(m_filled) == 8 && !m_err) m_done = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      chk("dout", dout, m_dout);
      chk("filled", filled, m_filled);
      chk("done", {7'd0, done}, {7'd0, m_done});
      chk("err", {7'd0, err}, {7'd0, m_err});
      chk("done_err_excl", {7'd0, done & err}, 8'd0);
   end

   task automatic cyc(input logic e, input logic v,
                      input logic [2:0] a, input logic d);
      en    = e;
      valid = v;
      addy  = a;
      din   = d;
      @(posedge clk);
      #1;
   endtask

   task automatic full_frame(input logic [7:0] w);
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 3'(i), w[i]);
   endtask

   initial begin
      logic [7:0] pat;
      logic [2:0] order [8];
      rst_n = 1'b0;
      en    = 1'b0;
      valid = 1'b0;
      addy  = '0;
      din   = 1'b0;
      #2;
      chk("rst_dout", dout, 8'h00);
      chk("rst_filled", filled, 8'h00);
      chk("rst_flags", {6'd0, done, err}, 8'd0);
      #10 rst_n = 1'b1;

      // in-order frame
      pat = 8'b0100_1101;
      full_frame(pat);
      chk("t1_done", {7'd0, done}, 8'd1);
      chk("t1_dout", dout, 8'b0100_1101);
      chk("t1_filled", filled, 8'hFF);
      cyc(1'b1, 1'b0, 3'd0, 1'b0);
      chk("t1_clear", filled, 8'h00);
      chk("t1_done_off", {7'd0, done}, 8'd0);
      chk("t1_hold", dout, 8'b0100_1101);

      // out-of-order with gaps
      order = '{3'd7, 3'd3, 3'd0, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4};
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b1, order[i], 1'b1);
         if (i < 7) begin
            chk("t2_no_done", {7'd0, done}, 8'd0);
            cyc(1'b1, 1'b0, 3'd0, 1'b0);
            cyc(1'b1, 1'b0, 3'd0, 1'b0);
         end
      end
      chk("t2_done", {7'd0, done}, 8'd1);
      chk("t2_dout", dout, 8'hFF);
      cyc(1'b1, 1'b0, 3'd0, 1'b0);

      // overwrite
      cyc(1'b1, 1'b1, 3'd2, 1'b1);
      cyc(1'b1, 1'b1, 3'd2, 1'b0);
      chk("t3_err", {7'd0, err}, 8'd1);
      chk("t3_bit2", {7'd0, dout[2]}, 8'd0);
      chk("t3_filled", filled, 8'h04);
      chk("t3_no_done", {7'd0, done}, 8'd0);
      cyc(1'b1, 1'b0, 3'd0, 1'b0);
      chk("t3_err_off", {7'd0, err}, 8'd0);

      // abort
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 3'(i), 1'b0);
      cyc(1'b0, 1'b1, 3'd5, 1'b1);
      chk("t4_filled", filled, 8'h00);
      chk("t4_no_done", {7'd0, done}, 8'd0);
      full_frame(8'hA5);
      chk("t4_done", {7'd0, done}, 8'd1);
      chk("t4_dout", dout, 8'hA5);

      // back-to-back frames
      cyc(1'b1, 1'b0, 3'd0, 1'b0);
      full_frame(8'h3C);
      chk("t5_done", {7'd0, done}, 8'd1);
      chk("t5_dout", dout, 8'h3C);
      cyc(1'b1, 1'b1, 3'd3, 1'b0);
      chk("t5_filled", filled, 8'h08);
      chk("t5_no_err", {7'd0, err}, 8'd0);
      chk("t5_no_done", {7'd0, done}, 8'd0);
      chk("t5_dout_b", dout, 8'h34);
      cyc(1'b0, 1'b0, 3'd0, 1'b0);

      // reset mid-frame, between edges
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 3'(i), 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_dout", dout, 8'h00);
      chk("t6_filled", filled, 8'h00);
      chk("t6_no_done", {7'd0, done}, 8'd0);
      #1 rst_n = 1'b1;
      full_frame(8'h96);
      chk("t6_done", {7'd0, done}, 8'd1);
      chk("t6_dout_rec", dout, 8'h96);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom_range(0, 19) != 0),
             ($urandom_range(0, 3) != 0),
             3'($urandom_range(0, 7)),
             1'($urandom));
      end
      cyc(1'b0, 1'b0, 3'd0, 1'b0);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
